counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
// PURPOSE
//   Shares one 8-bit load/increment counter (inputs data_in, ld, inc; output q) between
//   NUM_REQ requesters. Accepts commands over valid/ready and arbitrates round-robin.
//   Sequences the counter's ld/inc strobes, including multi-cycle increment bursts.
//   Returns the post-operation count to the winning requester. Sits directly in front of the counter.
// PARAMETERS
//   NUM_REQ  4  number of requesters (2..8)
//   WIDTH    8  counter data width; must match the counter
//   LEN_W    4  burst-length field width; INC performs req_len+1 increments (1..16)
// PORTS
//   clk        in   1                clock; all state updates on posedge
//   rst        in   1                asynchronous reset, active-low (0 = reset)
//   req_valid  in   [NUM_REQ-1:0]    command valid per requester
//   req_ready  out  [NUM_REQ-1:0]    command accepted (one-hot, one cycle)
//   req_op     in   [NUM_REQ-1:0][1:0] op: 00 READ, 01 LOAD, 10 INC, 11 reserved
//   req_data   in   [NUM_REQ-1:0][WIDTH-1:0] LOAD value
//   req_len    in   [NUM_REQ-1:0][LEN_W-1:0] INC burst length minus one
//   cnt_data   out  WIDTH            to counter data_in
//   cnt_ld     out  1                to counter ld
//   cnt_inc    out  1                to counter inc
//   cnt_q      in   WIDTH            from counter q
//   rsp_valid  out  1                response strobe, one cycle
//   rsp_id     out  $clog2(NUM_REQ)  requester index of the response
//   rsp_q      out  WIDTH            counter value after the operation
//   rsp_wrap   out  1                INC burst wrapped all-ones -> 0 at least once
//   rsp_err    out  1                op 11 received; no counter action
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, rr pointer 0, all outputs 0, burst count 0.
//   FSM: IDLE -> EXEC (LOAD/INC) or RESP (READ/11) -> IDLE.
//   IDLE: if any req_valid, grant the first valid index searching from the pointer, wrapping.
//     Assert req_ready[win] the same cycle (combinational). Latch win, op, data, len.
//   EXEC LOAD: one cycle; cnt_ld=1, cnt_data=latched data, cnt_inc=0.
//   EXEC INC: len+1 consecutive cycles; cnt_inc=1, cnt_ld=0. Burst counter decrements to 0.
//   Wrap detect: EXEC INC cycle with cnt_q=='1 sets a sticky wrap flag. Flag clears on IDLE grant.
//   RESP: rsp_valid=1; rsp_q=cnt_q (counter updated at the edge ending EXEC).
//     rsp_id=win, rsp_wrap=flag, rsp_err=(op==11). Pointer <= (win+1) mod NUM_REQ.
//   Latency: accept at cycle t; LOAD rsp at t+2; INC rsp at t+2+len; READ/11 rsp at t+1.
//   At most one grant per transaction; IDLE costs one cycle between transactions.
//   cnt_ld and cnt_inc are never high together; both are 0 outside EXEC.
//   Requesters hold valid/op/data/len until ready. Dropping valid early is illegal (SVA check).
//   Accepted ops always run to completion; later req changes are ignored.
//   cnt_data holds its last value outside LOAD; 0 after reset.
//   Reset mid-burst: strobes drop asynchronously; no rsp_valid; after reset, grant search starts at 0.
//   Counter arithmetic wraps modulo 2^WIDTH. Arbiter never saturates or blocks the counter.
// STRUCTURE
//   Package counter_arb_pkg: op_e (OP_READ, OP_LOAD, OP_INC, OP_RSVD), state_e (IDLE, EXEC, RESP).
//   Same package: default WIDTH/LEN_W localparams.
//   Sub-module cnt_rr_arbiter: combinational round-robin select.
//     Inputs: valid vector, pointer. Outputs: one-hot grant, index, any.
//   Top holds the FSM, latches, burst counter and wrap flag.
// TESTING (bench: counter_arbiter + counter + behavioural counter model, compared each negedge)
//   Hold rst=0 for 3 cycles with all req_valid=1 -> no ready, strobes and rsp all 0.
//   req 2 LOAD 8'hA5 -> ready[2] at t; cnt_ld=1, cnt_data=A5 at t+1; rsp t+2: q=A5, id=2.
//   LOAD 8'hFD, then INC len=3 -> cnt_inc high 4 cycles; rsp q=8'h01, rsp_wrap=1.
//   All 4 requesters continuously issuing READ -> grant order 0,1,2,3,0,1; no starvation.
//   INC len=15 from req 1, rst=0 mid-burst -> cnt_inc=0 immediately, no rsp; next grant to req 0.
//   req 3 op 11 -> no cnt_ld/cnt_inc; rsp at t+1 with rsp_err=1, rsp_q = current count.

Source files
------------

// File: rtl/counter_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_arb_pkg
// Purpose : Shared types and defaults for the counter arbiter slice.
//           Holds the op encoding, the FSM state encoding and a helper that
//           computes a wrapped index for the round-robin search.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package counter_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LEN_W   = 4;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // (base + off) mod n, for base < n and off <= n.
  function automatic int rr_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : counter_arbiter_if
// Purpose : Requester-side command and response bus of the counter arbiter.
// Ports   : req_valid/req_ready/req_op/req_data/req_len  command channel
//           rsp_valid/rsp_id/rsp_q/rsp_wrap/rsp_err      response strobe
//           modport master : requester side
//           modport slave  : arbiter side
// Revision: 1.0  initial release
// ============================================================================
interface counter_arbiter_if
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LEN_W   = DEF_LEN_W
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][1:0]        req_op;
  logic [NUM_REQ-1:0][WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;

  logic                           rsp_valid;
  logic [ID_W-1:0]                rsp_id;
  logic [WIDTH-1:0]               rsp_q;
  logic                           rsp_wrap;
  logic                           rsp_err;

  modport master (
    output req_valid, req_op, req_data, req_len,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_q, rsp_wrap, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_len,
    output req_ready,
    output rsp_valid, rsp_id, rsp_q, rsp_wrap, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/counter_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : cnt_rr_arbiter
// Purpose : Combinational round-robin select. Picks the first asserted
//           valid bit searching upward from ptr, wrapping at NUM_REQ.
// Ports   : valid  in  [NUM_REQ-1:0]  request vector
//           ptr    in  [ID_W-1:0]     search start index
//           grant  out [NUM_REQ-1:0]  one-hot winner
//           idx    out [ID_W-1:0]     winner index
//           any    out                at least one request present
// Revision: 1.0  initial release
// ============================================================================
module cnt_rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'(rr_index(int'(ptr), k, NUM_REQ));
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : counter_arbiter
// Purpose : Shares one load/increment counter between NUM_REQ requesters.
//           Round-robin grant, then drives the counter's ld/inc strobes
//           (INC runs req_len+1 cycles) and returns the resulting count.
// Ports   : clk       in   clock, posedge
//           rst       in   asynchronous reset, active-low
//           bus       slave modport of counter_arbiter_if (req/rsp channels)
//           cnt_data  out  counter data_in
//           cnt_ld    out  counter ld strobe
//           cnt_inc   out  counter inc strobe
//           cnt_q     in   counter q
// Revision: 1.0  initial release
// ============================================================================
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  counter_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]   cnt_data,
  output logic               cnt_ld,
  output logic               cnt_inc,
  input  logic [WIDTH-1:0]   cnt_q
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    win_q, win_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [LEN_W-1:0]   burst_q, burst_d;
  logic               wrap_q, wrap_d;

  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  op_e                new_op;

  // Requests are masked while reset is held so no ready leaks out.
  assign arb_valid = bus.req_valid & {NUM_REQ{rst}};
  assign new_op    = op_e'(bus.req_op[arb_idx]);
  assign cnt_data  = data_q;

  cnt_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid (arb_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      ptr_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      burst_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      data_q  <= data_d;
      burst_q <= burst_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    data_d        = data_q;
    burst_d       = burst_q;
    wrap_d        = wrap_q;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    bus.rsp_q     = '0;
    bus.rsp_wrap  = 1'b0;
    bus.rsp_err   = 1'b0;
    cnt_ld        = 1'b0;
    cnt_inc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          bus.req_ready = arb_grant;
          win_d         = arb_idx;
          op_d          = new_op;
          burst_d       = bus.req_len[arb_idx];
          wrap_d        = 1'b0;
          // cnt_data only moves on a LOAD so it holds between loads.
          if (new_op == OP_LOAD) data_d = bus.req_data[arb_idx];
          state_d = (new_op == OP_LOAD || new_op == OP_INC) ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (op_q == OP_LOAD) begin
          cnt_ld  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
          // All-ones now means this increment rolls over to zero.
          if (cnt_q == '1) wrap_d = 1'b1;
          if (burst_q == '0) state_d = RESP;
          else               burst_d = burst_q - LEN_W'(1);
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = win_q;
        bus.rsp_q     = cnt_q;
        bus.rsp_wrap  = wrap_q;
        bus.rsp_err   = (op_q == OP_RSVD);
        ptr_d         = ID_W'(rr_index(int'(win_q), 1, NUM_REQ));
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A requester must keep valid asserted until it sees ready.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst)
      (bus.req_valid[g] && !bus.req_ready[g]) |=> bus.req_valid[g]);
  end

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst)
    !(cnt_ld && cnt_inc));

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_arbiter
// Purpose : Directed self-checking bench for counter_arbiter driving a
//           simple load/increment counter.
// Revision: 1.0  initial release
// ============================================================================
module tb_counter_arbiter;
  import counter_arb_pkg::*;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int LW = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] cnt_data;
  logic         cnt_ld;
  logic         cnt_inc;
  logic [W-1:0] cnt_q;

  int total;
  int bad;

  counter_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .LEN_W(LW)) bus ();

  counter_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cnt_data (cnt_data),
    .cnt_ld   (cnt_ld),
    .cnt_inc  (cnt_inc),
    .cnt_q    (cnt_q)
  );

  // The shared counter sitting behind the arbiter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt_q <= '0;
    else if (cnt_ld)  cnt_q <= cnt_data;
    else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input int id, input logic [1:0] op,
                       input logic [7:0] data, input logic [3:0] len);
    bus.req_op[id]    = op;
    bus.req_data[id]  = data;
    bus.req_len[id]   = len;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.req_valid = '1;
    bus.req_op    = '0;
    bus.req_data  = '0;
    bus.req_len   = '0;
    repeat (3) begin
      @(negedge clk);
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
      total++; if ({cnt_ld, cnt_inc} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {cnt_ld, cnt_inc}); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
      total++; if (cnt_data !== 8'h00) begin bad++; $display("FAIL reset_cnt_data: got %h want 00", cnt_data); end
      total++; if ({bus.rsp_q, bus.rsp_id} !== 10'h0) begin bad++; $display("FAIL reset_rsp_q_id: got %h want 000", {bus.rsp_q, bus.rsp_id}); end
    end
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_load();
    issue(2, OP_LOAD, 8'hA5, 4'd0);
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL load_ready: got %b want 0100", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    total++; if ({cnt_ld, cnt_inc} !== 2'b10) begin bad++; $display("FAIL load_strobes: got %b want 10", {cnt_ld, cnt_inc}); end
    total++; if (cnt_data !== 8'hA5) begin bad++; $display("FAIL load_cnt_data: got %h want a5", cnt_data); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL load_early_rsp: got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL load_rsp_valid: got %b want 1", bus.rsp_valid); end
    total++; if (bus.rsp_q !== 8'hA5) begin bad++; $display("FAIL load_rsp_q: got %h want a5", bus.rsp_q); end
    total++; if (bus.rsp_id !== 2'd2) begin bad++; $display("FAIL load_rsp_id: got %0d want 2", bus.rsp_id); end
    total++; if ({bus.rsp_err, bus.rsp_wrap, cnt_ld} !== 3'b000) begin bad++; $display("FAIL load_rsp_flags: got %b want 000", {bus.rsp_err, bus.rsp_wrap, cnt_ld}); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    // Pointer is 3 after the last grant; req 0 is next in the search.
    issue(0, OP_LOAD, 8'hFD, 4'd0);
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_load_ready: got %b want 0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.rsp_q !== 8'hFD) begin bad++; $display("FAIL wrap_load_q: got %h want fd", bus.rsp_q); end
    @(posedge clk); #1;
    issue(0, OP_INC, 8'h00, 4'd3);
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_inc_ready: got %b want 0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({cnt_ld, cnt_inc, bus.rsp_valid} !== 3'b010) begin bad++; $display("FAIL wrap_inc_cycle%0d: got %b want 010", i, {cnt_ld, cnt_inc, bus.rsp_valid}); end
    end
    @(negedge clk);
    total++; if (cnt_inc !== 1'b0) begin bad++; $display("FAIL wrap_inc_stop: got %b want 0", cnt_inc); end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL wrap_rsp_valid: got %b want 1", bus.rsp_valid); end
    total++; if (bus.rsp_q !== 8'h01) begin bad++; $display("FAIL wrap_rsp_q: got %h want 01", bus.rsp_q); end
    total++; if (bus.rsp_wrap !== 1'b1) begin bad++; $display("FAIL wrap_flag: got %b want 1", bus.rsp_wrap); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL wrap_rsp_id: got %0d want 0", bus.rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
    // Pointer is 1; only req 3 asks.
    issue(3, OP_RSVD, 8'h55, 4'd5);
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL rsvd_ready: got %b want 1000", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    total++; if ({cnt_ld, cnt_inc} !== 2'b00) begin bad++; $display("FAIL rsvd_strobes: got %b want 00", {cnt_ld, cnt_inc}); end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rsvd_rsp_valid: got %b want 1", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL rsvd_err: got %b want 1", bus.rsp_err); end
    total++; if (bus.rsp_q !== 8'h01) begin bad++; $display("FAIL rsvd_rsp_q: got %h want 01", bus.rsp_q); end
    total++; if (bus.rsp_id !== 2'd3) begin bad++; $display("FAIL rsvd_rsp_id: got %0d want 3", bus.rsp_id); end
    total++; if (bus.rsp_wrap !== 1'b0) begin bad++; $display("FAIL rsvd_wrap_cleared: got %b want 0", bus.rsp_wrap); end
    total++; if (cnt_data !== 8'hFD) begin bad++; $display("FAIL rsvd_cnt_data_hold: got %h want fd", cnt_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int          quota [NR];
    logic [3:0]  oh;
    int          exp_id;
    for (int i = 0; i < NR; i++) begin
      quota[i] = 2;
      issue(i, OP_READ, 8'h00, 4'd0);
    end
    for (int g = 0; g < 8; g++) begin
      exp_id = g % NR;
      oh     = 4'b0001 << exp_id;
      @(negedge clk);
      total++; if (bus.req_ready !== oh) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", g, bus.req_ready, oh); end
      @(posedge clk); #1;
      if (bus.req_ready == 4'b0000) begin end
      quota[exp_id] = quota[exp_id] - 1;
      if (quota[exp_id] == 0) bus.req_valid[exp_id] = 1'b0;
      @(negedge clk);
      total++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'(exp_id)}) begin bad++; $display("FAIL rr_rsp%0d: got %b want %b", g, {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'(exp_id)}); end
      total++; if (bus.rsp_q !== 8'h01) begin bad++; $display("FAIL rr_rsp_q%0d: got %h want 01", g, bus.rsp_q); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    // Move the pointer to 2 first so a pointer that survives reset shows up.
    issue(1, OP_READ, 8'h00, 4'd0);
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL mid_read_ready: got %b want 0010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    issue(1, OP_INC, 8'h00, 4'd15);
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL mid_inc_ready: got %b want 0010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    total++; if (cnt_inc !== 1'b1) begin bad++; $display("FAIL mid_inc_active: got %b want 1", cnt_inc); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if ({cnt_ld, cnt_inc} !== 2'b00) begin bad++; $display("FAIL mid_strobe_drop: got %b want 00", {cnt_ld, cnt_inc}); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp: got %b want 0", bus.rsp_valid); end
    issue(0, OP_READ, 8'h00, 4'd0);
    issue(3, OP_READ, 8'h00, 4'd0);
    repeat (2) begin
      @(negedge clk);
      total++; if ({bus.rsp_valid, cnt_inc, bus.req_ready} !== 6'b0) begin bad++; $display("FAIL mid_in_reset: got %b want 000000", {bus.rsp_valid, cnt_inc, bus.req_ready}); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_q} !== {1'b1, 2'd0, 8'h00}) begin bad++; $display("FAIL mid_rsp0: got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_q}, {1'b1, 2'd0, 8'h00}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL mid_second_grant: got %b want 1000", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    total++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'd3}) begin bad++; $display("FAIL mid_rsp3: got %b want 111", {bus.rsp_valid, bus.rsp_id}); end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load();
    test_wrap();
    test_reserved();
    test_round_robin();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
